// File: rtl/core_types_pkg.sv
// Shared front-end predictor types: return address stack sizing and checkpoint field types.
package core_types_pkg;

    localparam int unsigned BTB_TARGET_WIDTH = 12;
    localparam int unsigned RAS_DEPTH        = 8;
    localparam int unsigned RAS_TARGET_WIDTH = BTB_TARGET_WIDTH;
    localparam int unsigned LOG_RAS_DEPTH    = $clog2(RAS_DEPTH);

    typedef logic [LOG_RAS_DEPTH-1:0]    ras_index_t;
    typedef logic [LOG_RAS_DEPTH:0]      ras_count_t;
    typedef logic [RAS_TARGET_WIDTH-1:0] ras_target_t;

    localparam ras_count_t RAS_FULL = ras_count_t'(RAS_DEPTH);

endpackage

// File: rtl/ras.sv
// Circular return address stack with one-cycle checkpoint restore.
// Define RAS_STATS_EN to add saturating overflow/underflow event counters.
module ras
    import core_types_pkg::*;
(
    input  logic        CLK,
    input  logic        nRST,
    input  logic        push_valid,
    input  ras_target_t push_target,
    input  logic        pop_valid,
    input  logic        restore_valid,
    input  ras_index_t  restore_index,
    input  ras_count_t  restore_count,
    output ras_target_t ret_target_out,
    output logic        ret_valid_out,
    output ras_index_t  index_out,
    output ras_count_t  count_out
`ifdef RAS_STATS_EN
    ,
    output logic [15:0] overflow_count_out,
    output logic [15:0] underflow_count_out
`endif
);

    ras_target_t entry_q [RAS_DEPTH];
    ras_target_t entry_d [RAS_DEPTH];
    ras_index_t  tos_q, tos_d;
    ras_count_t  count_q, count_d;
    ras_index_t  tos_inc, tos_dec;

    assign tos_inc = tos_q + ras_index_t'(1);
    assign tos_dec = tos_q - ras_index_t'(1);

    always_comb begin
        entry_d = entry_q;
        tos_d   = tos_q;
        count_d = count_q;
        if (restore_valid) begin
            tos_d   = restore_index;
            count_d = (restore_count > RAS_FULL) ? RAS_FULL : restore_count;
        end else if (push_valid && pop_valid) begin
            // Return then call: replace the top in place.
            entry_d[tos_q] = push_target;
            if (count_q == '0) begin
                count_d = ras_count_t'(1);
            end
        end else if (push_valid) begin
            tos_d            = tos_inc;
            entry_d[tos_inc] = push_target;
            if (count_q != RAS_FULL) begin
                count_d = count_q + ras_count_t'(1);
            end
        end else if (pop_valid && count_q != '0) begin
            tos_d   = tos_dec;
            count_d = count_q - ras_count_t'(1);
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            tos_q   <= '0;
            count_q <= '0;
            for (int i = 0; i < RAS_DEPTH; i++) begin
                entry_q[i] <= '0;
            end
        end else begin
            tos_q   <= tos_d;
            count_q <= count_d;
            entry_q <= entry_d;
        end
    end

    assign ret_target_out = entry_q[tos_q];
    assign ret_valid_out  = (count_q != '0);
    assign index_out      = tos_q;
    assign count_out      = count_q;

`ifdef RAS_STATS_EN
    logic [15:0] ovf_q, ovf_d;
    logic [15:0] unf_q, unf_d;

    always_comb begin
        ovf_d = ovf_q;
        unf_d = unf_q;
        if (!restore_valid) begin
            if (push_valid && !pop_valid && count_q == RAS_FULL && ovf_q != 16'hFFFF) begin
                ovf_d = ovf_q + 16'd1;
            end
            if (pop_valid && !push_valid && count_q == '0 && unf_q != 16'hFFFF) begin
                unf_d = unf_q + 16'd1;
            end
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            ovf_q <= '0;
            unf_q <= '0;
        end else begin
            ovf_q <= ovf_d;
            unf_q <= unf_d;
        end
    end

    assign overflow_count_out  = ovf_q;
    assign underflow_count_out = unf_q;
`endif

endmodule

// File: tb/tb_ras.sv
// Randomized and directed bench for ras against an array-based stack reference model.
module tb_ras;
    import core_types_pkg::*;

    logic        CLK;
    logic        nRST;
    logic        push_valid;
    ras_target_t push_target;
    logic        pop_valid;
    logic        restore_valid;
    ras_index_t  restore_index;
    ras_count_t  restore_count;
    ras_target_t ret_target_out;
    logic        ret_valid_out;
    ras_index_t  index_out;
    ras_count_t  count_out;
`ifdef RAS_STATS_EN
    logic [15:0] overflow_count_out;
    logic [15:0] underflow_count_out;
`endif

    ras dut (
        .CLK            (CLK),
        .nRST           (nRST),
        .push_valid     (push_valid),
        .push_target    (push_target),
        .pop_valid      (pop_valid),
        .restore_valid  (restore_valid),
        .restore_index  (restore_index),
        .restore_count  (restore_count),
        .ret_target_out (ret_target_out),
        .ret_valid_out  (ret_valid_out),
        .index_out      (index_out),
        .count_out      (count_out)
`ifdef RAS_STATS_EN
        ,
        .overflow_count_out  (overflow_count_out),
        .underflow_count_out (underflow_count_out)
`endif
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int n_checks = 0;
    int n_fails  = 0;

    // Reference model: plain integers and an array.
    int m_tos;
    int m_cnt;
    int m_mem [RAS_DEPTH];
    int m_ovf;
    int m_unf;

    task automatic check(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs !== exp) begin
            n_fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_tos = 0;
        m_cnt = 0;
        m_ovf = 0;
        m_unf = 0;
        for (int i = 0; i < RAS_DEPTH; i++) m_mem[i] = 0;
    endtask

    task automatic model_step(input bit pu, input int tg, input bit po,
                              input bit rs, input int ri, input int rc);
        if (rs) begin
            m_tos = ri;
            m_cnt = (rc > RAS_DEPTH) ? RAS_DEPTH : rc;
        end else if (pu && po) begin
            m_mem[m_tos] = tg;
            if (m_cnt == 0) m_cnt = 1;
        end else if (pu) begin
            if (m_cnt == RAS_DEPTH && m_ovf < 65535) m_ovf++;
            m_tos = (m_tos + 1) % RAS_DEPTH;
            m_mem[m_tos] = tg;
            if (m_cnt < RAS_DEPTH) m_cnt++;
        end else if (po) begin
            if (m_cnt > 0) begin
                m_tos = (m_tos + RAS_DEPTH - 1) % RAS_DEPTH;
                m_cnt--;
            end else if (m_unf < 65535) begin
                m_unf++;
            end
        end
    endtask

    task automatic check_all();
        check("top",   int'(ret_target_out), m_mem[m_tos]);
        check("valid", int'(ret_valid_out),  (m_cnt != 0) ? 1 : 0);
        check("index", int'(index_out),      m_tos);
        check("count", int'(count_out),      m_cnt);
`ifdef RAS_STATS_EN
        check("ovf",   int'(overflow_count_out),  m_ovf);
        check("unf",   int'(underflow_count_out), m_unf);
`endif
    endtask

    task automatic idle_inputs();
        push_valid    = 1'b0;
        push_target   = '0;
        pop_valid     = 1'b0;
        restore_valid = 1'b0;
        restore_index = '0;
        restore_count = '0;
    endtask

    task automatic step(input bit pu, input int tg, input bit po,
                        input bit rs, input int ri, input int rc);
        push_valid    = pu;
        push_target   = ras_target_t'(tg);
        pop_valid     = po;
        restore_valid = rs;
        restore_index = ras_index_t'(ri);
        restore_count = ras_count_t'(rc);
        @(posedge CLK);
        model_step(pu, tg, po, rs, ri, rc);
        #1;
        idle_inputs();
        check_all();
    endtask

    task automatic push(input int tg);
        step(1'b1, tg, 1'b0, 1'b0, 0, 0);
    endtask

    task automatic pop();
        step(1'b0, 0, 1'b1, 1'b0, 0, 0);
    endtask

    // Asynchronous reset pulse placed between clock edges, with a push pending.
    task automatic pulse_reset();
        push_valid  = 1'b1;
        push_target = 12'hABC;
        nRST = 1'b0;
        #1;
        model_reset();
        check("rst_top",   int'(ret_target_out), 0);
        check("rst_valid", int'(ret_valid_out),  0);
        check("rst_index", int'(index_out),      0);
        check("rst_count", int'(count_out),      0);
        check_all();
        #1;
        nRST = 1'b1;
        idle_inputs();
    endtask

    initial begin
        idle_inputs();
        nRST = 1'b0;
        model_reset();
        #12;
        check_all();
        nRST = 1'b1;
        @(posedge CLK);
        #1;
        check_all();

        push(12'h111);
        push(12'h222);
        push(12'h333);
        check("tp3_top",   int'(ret_target_out), 'h333);
        check("tp3_count", int'(count_out),      3);
        check("tp3_index", int'(index_out),      3);
        pop();
        check("tp3_pop_top", int'(ret_target_out), 'h222);
        check("tp3_pop_idx", int'(index_out),      2);

        pulse_reset();
        for (int i = 1; i <= 9; i++) push(i);
        check("sat_count", int'(count_out),      8);
        check("sat_index", int'(index_out),      1);
        check("sat_top",   int'(ret_target_out), 9);
        for (int i = 0; i < 7; i++) pop();
        check("pop7_top", int'(ret_target_out), 2);
        pop();
        check("empty_count", int'(count_out),     0);
        check("empty_valid", int'(ret_valid_out), 0);
        pop();
        check("undf_count", int'(count_out), 0);
`ifdef RAS_STATS_EN
        check("undf_stat", int'(underflow_count_out), 1);
        check("ovf_stat",  int'(overflow_count_out),  1);
`endif

        // Push+pop on empty stack, then on a non-empty one.
        step(1'b1, 'h077, 1'b1, 1'b0, 0, 0);
        check("pp_empty_count", int'(count_out),      1);
        check("pp_empty_top",   int'(ret_target_out), 'h077);
        pulse_reset();
        push('h0AA);
        push('h0BB);
        step(1'b1, 'h0CC, 1'b1, 1'b0, 0, 0);
        check("pp_top",   int'(ret_target_out), 'h0CC);
        check("pp_count", int'(count_out),      2);
        check("pp_index", int'(index_out),      2);

        // Wrong-path activity then restore with a push that must be ignored.
        push('h0DD);
        push('h0EE);
        pop();
        step(1'b1, 'h0FF, 1'b0, 1'b1, 2, 2);
        check("rst_idx",   int'(index_out), 2);
        check("rst_cnt",   int'(count_out), 2);

        step(1'b0, 0, 1'b0, 1'b1, 7, 9);
        check("clamp_count", int'(count_out), 8);
        push('h123);
        check("wrap_up_idx", int'(index_out), 0);
        pop();
        check("wrap_dn_idx", int'(index_out), 7);

        for (int n = 0; n < 1500; n++) begin
            bit rs;
            rs = ($urandom_range(15) == 0);
            step(1'($urandom), int'($urandom_range(4095)), 1'($urandom), rs,
                 int'($urandom_range(RAS_DEPTH - 1)), int'($urandom_range(15)));
            if ($urandom_range(399) == 0) pulse_reset();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
